// File: rtl/race_pkg.sv
// -----------------------------------------------------------------------------
// race_pkg
// Shared types and defaults for the race judge and its observer bench.
//   state_t      : judge FSM states (IDLE, RACE, RELEASE)
//   idx_w()      : width of a racer index, never less than one bit
//   *_DEF        : default racer count, counter width and timeout
// -----------------------------------------------------------------------------
package race_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RACE    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int N_RACERS_DEF = 4;
    localparam int CNT_W_DEF    = 16;
    localparam int TIMEOUT_DEF  = 1000;

    function automatic int idx_w(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/race_judge_if.sv
// -----------------------------------------------------------------------------
// race_judge_if
// Bundles the observer handshake (start/done_in), the race request (go) and
// the published result fields of the race judge.
//   master : judge side (drives start, busy and the result fields)
//   slave  : controller/observer side (drives go and done_in)
// Optional ranking signals (place, place_cnt) exist only when
// RACE_JUDGE_RANKING_EN is defined.
// -----------------------------------------------------------------------------
interface race_judge_if #(
    parameter int N_RACERS = race_pkg::N_RACERS_DEF,
    parameter int CNT_W    = race_pkg::CNT_W_DEF
);
    localparam int IDX_W = race_pkg::idx_w(N_RACERS);

    logic                  go;
    logic [N_RACERS-1:0]   done_in;
    logic [N_RACERS-1:0]   start;
    logic                  busy;
    logic                  result_valid;
    logic [IDX_W-1:0]      winner;
    logic                  tie;
    logic [CNT_W-1:0]      first_time;
    logic [N_RACERS-1:0]   finished;
    logic                  timeout;
`ifdef RACE_JUDGE_RANKING_EN
    logic [N_RACERS*IDX_W-1:0] place;
    logic [IDX_W:0]            place_cnt;
`endif

`ifdef RACE_JUDGE_RANKING_EN
    modport master (
        input  go, done_in,
        output start, busy, result_valid, winner, tie, first_time, finished, timeout,
        output place, place_cnt
    );
    modport slave (
        output go, done_in,
        input  start, busy, result_valid, winner, tie, first_time, finished, timeout,
        input  place, place_cnt
    );
`else
    modport master (
        input  go, done_in,
        output start, busy, result_valid, winner, tie, first_time, finished, timeout
    );
    modport slave (
        output go, done_in,
        input  start, busy, result_valid, winner, tie, first_time, finished, timeout
    );
`endif

endinterface

// File: rtl/lowest_set_index.sv
// -----------------------------------------------------------------------------
// lowest_set_index
// Combinational priority encoder.
//   vec_i   : input vector (W bits)
//   idx_o   : index of the lowest set bit (0 when vec_i is zero)
//   any_o   : at least one bit set
//   multi_o : more than one bit set
// -----------------------------------------------------------------------------
module lowest_set_index #(
    parameter int W  = 4,
    parameter int IW = 2
) (
    input  logic [W-1:0]  vec_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o,
    output logic          multi_o
);

    always_comb begin
        idx_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

    assign any_o   = |vec_i;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_o = |(vec_i & (vec_i - W'(1)));

endmodule

// File: rtl/race_judge.sv
// -----------------------------------------------------------------------------
// race_judge
// Upstream controller for a bank of race observers (four-phase start/done).
// On go it raises every start line, times the race, records the first
// finisher, tie status and finish mask, drops start, waits for all done lines
// to return low and then publishes the result.
//   clk   : system clock, rising edge
//   rst_l : asynchronous active-low reset
//   bus   : race_judge_if.master (go, done_in, start, busy, result fields)
// Parameters: N_RACERS (2..16), CNT_W (counter width), TIMEOUT (< 2**CNT_W).
// Optional feature macro: RACE_JUDGE_RANKING_EN adds the finish-order outputs
// place / place_cnt.
// -----------------------------------------------------------------------------
module race_judge
    import race_pkg::*;
#(
    parameter int N_RACERS = N_RACERS_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst_l,
    race_judge_if.master bus
);

    localparam int               IDX_W = idx_w(N_RACERS);
    localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);

    state_t              state_q, state_d;
    logic [N_RACERS-1:0] start_q, start_d;
    logic [N_RACERS-1:0] seen_q, seen_d;
    logic [N_RACERS-1:0] finished_q, finished_d;
    logic                busy_q, busy_d;
    logic                rv_q, rv_d;
    logic                tie_q, tie_d;
    logic                timeout_q, timeout_d;
    logic [IDX_W-1:0]    winner_q, winner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    first_q, first_d;

    logic [N_RACERS-1:0] seen_nx;
    logic [IDX_W-1:0]    din_idx;
    logic                din_any;
    logic                din_multi;

    assign seen_nx = seen_q | bus.done_in;

    lowest_set_index #(.W(N_RACERS), .IW(IDX_W)) u_first (
        .vec_i   (bus.done_in),
        .idx_o   (din_idx),
        .any_o   (din_any),
        .multi_o (din_multi)
    );

    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        seen_d     = seen_q;
        finished_d = finished_q;
        busy_d     = busy_q;
        rv_d       = rv_q;
        tie_d      = tie_q;
        timeout_d  = timeout_q;
        winner_d   = winner_q;
        cnt_d      = cnt_q;
        first_d    = first_q;

        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    start_d    = '1;
                    busy_d     = 1'b1;
                    rv_d       = 1'b0;
                    cnt_d      = CNT_W'(1);
                    seen_d     = '0;
                    finished_d = '0;
                    winner_d   = '0;
                    tie_d      = 1'b0;
                    first_d    = '0;
                    timeout_d  = 1'b0;
                    state_d    = RACE;
                end
            end
            RACE: begin
                seen_d = seen_nx;
                // Only the very first cycle with any done decides the winner.
                if (din_any && (seen_q == '0)) begin
                    winner_d = din_idx;
                    tie_d    = din_multi;
                    first_d  = cnt_q;
                end
                // All-finished takes priority over a coincident timeout.
                if (&seen_nx) begin
                    start_d    = '0;
                    finished_d = seen_nx;
                    timeout_d  = 1'b0;
                    state_d    = RELEASE;
                end else if (cnt_q == TMO) begin
                    start_d    = '0;
                    finished_d = seen_nx;
                    timeout_d  = 1'b1;
                    state_d    = RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                // go is not sampled here, so a go on the exit cycle is dropped.
                if (bus.done_in == '0) begin
                    rv_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                start_d    = '0;
                seen_d     = '0;
                finished_d = '0;
                busy_d     = 1'b0;
                rv_d       = 1'b0;
                tie_d      = 1'b0;
                timeout_d  = 1'b0;
                winner_d   = '0;
                cnt_d      = '0;
                first_d    = '0;
            end
        endcase
    end

`ifdef RACE_JUDGE_RANKING_EN
    // Finish-order ranking: a chain of encoders peels new finishers off in
    // ascending index order, one per slot.
    logic [N_RACERS-1:0]                 new_fin;
    logic [N_RACERS-1:0]                 rem [N_RACERS];
    logic [IDX_W-1:0]                    rk_idx [N_RACERS];
    logic [N_RACERS-1:0]                 rk_any;
    logic [N_RACERS-1:0]                 rk_multi;
    logic [N_RACERS-1:0][IDX_W-1:0]      place_q, place_d;
    logic [IDX_W:0]                      pcnt_q, pcnt_d;

    assign new_fin = (state_q == RACE) ? (bus.done_in & ~seen_q) : '0;
    assign rem[0]  = new_fin;

    for (genvar k = 0; k < N_RACERS; k++) begin : g_rank
        lowest_set_index #(.W(N_RACERS), .IW(IDX_W)) u_rk (
            .vec_i   (rem[k]),
            .idx_o   (rk_idx[k]),
            .any_o   (rk_any[k]),
            .multi_o (rk_multi[k])
        );
        if (k < N_RACERS - 1) begin : g_next
            assign rem[k+1] = rem[k] & ~(N_RACERS'(1) << rk_idx[k]);
        end
    end

    always_comb begin
        logic [IDX_W:0] slot;
        place_d = place_q;
        pcnt_d  = pcnt_q;
        slot    = '0;
        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    place_d = '0;
                    pcnt_d  = '0;
                end
            end
            RACE: begin
                for (int k = 0; k < N_RACERS; k++) begin
                    slot = pcnt_q + (IDX_W+1)'(k);
                    if (rk_any[k] && (slot < (IDX_W+1)'(N_RACERS))) begin
                        place_d[slot[IDX_W-1:0]] = rk_idx[k];
                    end
                end
                // Each encoder's multi flag means one more finisher follows it.
                pcnt_d = pcnt_q + (IDX_W+1)'(rk_any[0]) + (IDX_W+1)'($countones(rk_multi));
            end
            RELEASE: begin
            end
            default: begin
                place_d = '0;
                pcnt_d  = '0;
            end
        endcase
    end

    assign bus.place     = place_q;
    assign bus.place_cnt = pcnt_q;
`endif

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= IDLE;
            start_q    <= '0;
            seen_q     <= '0;
            finished_q <= '0;
            busy_q     <= 1'b0;
            rv_q       <= 1'b0;
            tie_q      <= 1'b0;
            timeout_q  <= 1'b0;
            winner_q   <= '0;
            cnt_q      <= '0;
            first_q    <= '0;
`ifdef RACE_JUDGE_RANKING_EN
            place_q    <= '0;
            pcnt_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            seen_q     <= seen_d;
            finished_q <= finished_d;
            busy_q     <= busy_d;
            rv_q       <= rv_d;
            tie_q      <= tie_d;
            timeout_q  <= timeout_d;
            winner_q   <= winner_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
`ifdef RACE_JUDGE_RANKING_EN
            place_q    <= place_d;
            pcnt_q     <= pcnt_d;
`endif
        end
    end

    assign bus.start        = start_q;
    assign bus.busy         = busy_q;
    assign bus.result_valid = rv_q;
    assign bus.winner       = winner_q;
    assign bus.tie          = tie_q;
    assign bus.first_time   = first_q;
    assign bus.finished     = finished_q;
    assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_race_judge.sv
// -----------------------------------------------------------------------------
// tb_race_judge
// Scoreboard bench for race_judge (N_RACERS=4, CNT_W=16, TIMEOUT=20).
// The driver issues directed races and pushes hand-computed results; a
// monitor pops and compares whenever result_valid rises.
// -----------------------------------------------------------------------------
module tb_race_judge;

    localparam int N  = 4;
    localparam int CW = 16;
    localparam int TO = 20;

    typedef struct packed {
        logic [1:0]  winner;
        logic        tie;
        logic [15:0] first;
        logic [3:0]  fin;
        logic        tmo;
        logic [7:0]  place;
        logic [2:0]  pcnt;
    } exp_t;

    logic clk;
    logic rst_l;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    logic prev_rv;

    race_judge_if #(.N_RACERS(N), .CNT_W(CW)) bus ();

    race_judge #(.N_RACERS(N), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: compare published results against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_l) begin
            prev_rv = 1'b0;
        end else begin
            if (bus.result_valid && !prev_rv) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_result", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("winner",     64'(bus.winner),     64'(e.winner));
                    check("tie",        64'(bus.tie),        64'(e.tie));
                    check("first_time", 64'(bus.first_time), 64'(e.first));
                    check("finished",   64'(bus.finished),   64'(e.fin));
                    check("timeout",    64'(bus.timeout),    64'(e.tmo));
`ifdef RACE_JUDGE_RANKING_EN
                    check("place",      64'(bus.place),      64'(e.place));
                    check("place_cnt",  64'(bus.place_cnt),  64'(e.pcnt));
`endif
                end
            end
            prev_rv = bus.result_valid;
        end
    end

    // t_i = counter value at which racer i raises done (0 = never).
    // p0..p3 = expected finish-order slots.
    task automatic run_race(input int t0, input int t1, input int t2, input int t3,
                            input int win, input int tie, input int first,
                            input int fin, input int tmo, input int end_cnt,
                            input int p0, input int p1, input int p2, input int p3,
                            input int pc, input int go_mid, input bit go_exit);
        exp_t e;
        int   t[4];
        int   k;
        logic [3:0] d;
        t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
        e.winner = 2'(win);
        e.tie    = 1'(tie);
        e.first  = 16'(first);
        e.fin    = 4'(fin);
        e.tmo    = 1'(tmo);
        e.place  = {2'(p3), 2'(p2), 2'(p1), 2'(p0)};
        e.pcnt   = 3'(pc);
        bus.go = 1'b1;
        sb.push_back(e);
        k = 1;
        forever begin
            @(negedge clk);
            bus.go = 1'b0;
            if (k == 1) begin
                check("busy_on_accept",  64'(bus.busy),         64'd1);
                check("start_on_accept", 64'(bus.start),        64'hf);
                check("rv_cleared",      64'(bus.result_valid), 64'd0);
            end
            if (bus.start == 4'b0) break;
            if (k > 60) begin
                check("race_end_bound", 64'(k), 64'(end_cnt + 1));
                break;
            end
            d = 4'b0;
            for (int i = 0; i < 4; i++) begin
                if (t[i] != 0 && t[i] <= k) d[i] = 1'b1;
            end
            bus.done_in = d;
            bus.go = (k == go_mid);
            k++;
        end
        check("race_end_cnt", 64'(k - 1), 64'(end_cnt));
        bus.done_in = 4'b0;
        bus.go = go_exit;
        @(negedge clk);
        bus.go = 1'b0;
        check("busy_after_release", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        prev_rv  = 1'b0;
        rst_l    = 1'b0;
        bus.go      = 1'b0;
        bus.done_in = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start",  64'(bus.start),        64'd0);
        check("rst_busy",   64'(bus.busy),         64'd0);
        check("rst_rv",     64'(bus.result_valid), 64'd0);
        check("rst_winner", 64'(bus.winner),       64'd0);
        check("rst_first",  64'(bus.first_time),   64'd0);
        @(negedge clk);
        rst_l = 1'b1;

        // Asynchronous reset in the middle of a race.
        @(negedge clk);
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_start", 64'(bus.start), 64'hf);
        @(posedge clk);
        #2;
        rst_l = 1'b0;
        #1;
        check("async_rst_start",    64'(bus.start),        64'd0);
        check("async_rst_busy",     64'(bus.busy),         64'd0);
        check("async_rst_rv",       64'(bus.result_valid), 64'd0);
        check("async_rst_finished", 64'(bus.finished),     64'd0);
        check("async_rst_timeout",  64'(bus.timeout),      64'd0);
        check("async_rst_tie",      64'(bus.tie),          64'd0);
`ifdef RACE_JUDGE_RANKING_EN
        check("async_rst_pcnt",     64'(bus.place_cnt),    64'd0);
`endif
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);

        // Single winner: racer 2 at 5, then 0/1/3 at 8/9/12.
        run_race(8, 9, 5, 12,  2, 0, 5,  4'hf, 0, 12,  2, 0, 1, 3, 4,  0, 1'b0);
        // Tie: racers 1 and 3 at 7, others at 10.
        run_race(10, 7, 10, 7, 1, 1, 7,  4'hf, 0, 10,  1, 3, 0, 2, 4,  0, 1'b0);
        // Timeout: racer 0 silent, others by 15.
        run_race(0, 12, 15, 4, 3, 0, 4,  4'he, 1, 20,  3, 1, 2, 0, 3,  0, 1'b0);
        // Busy protection: go mid-race and on the release-exit cycle.
        run_race(2, 3, 4, 5,   0, 0, 2,  4'hf, 0, 5,   0, 1, 2, 3, 4,  3, 1'b1);
        // Next go one cycle after IDLE is accepted: timeout with no finisher.
        run_race(0, 0, 0, 0,   0, 0, 0,  4'h0, 1, 20,  0, 0, 0, 0, 0,  0, 1'b0);
        // Everyone in the very first counted cycle.
        run_race(1, 1, 1, 1,   0, 1, 1,  4'hf, 0, 1,   0, 1, 2, 3, 4,  0, 1'b0);
        // Last finishers coincide with the timeout edge: all-finished wins.
        run_race(20, 3, 20, 20, 1, 0, 3, 4'hf, 0, 20,  1, 0, 2, 3, 4,  0, 1'b0);
        // Ranking order 3, then 0 and 2 together, then 1.
        run_race(6, 9, 6, 4,   3, 0, 4,  4'hf, 0, 9,   3, 0, 2, 1, 4,  0, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/race_judge.md
Name: race_judge

Overview:
- Upstream controller for a bank of race observers, using a four-phase start/done handshake.
- On a `go` request it raises a per-racer `start` line and times the race in clock cycles.
- It records the first finisher, the tie status and the finish mask, then drops `start` and waits for every `done` to return low.
- It then publishes the result to the top-level status logic.

Parameters:
- N_RACERS, 4, number of observers driven; range 2..16.
- CNT_W, 16, width of the race cycle counter.
- TIMEOUT, 1000, cycles after start assertion at which the race is force-ended; must be < 2**CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_l  in  1  asynchronous, active-low reset.
- go  in  1  race request; sampled only in IDLE.
- done_in  in  N_RACERS  done from each observer; same clock domain.
- start  out  N_RACERS  start to each observer; registered.
- busy  out  1  high from `go` acceptance until return to IDLE.
- result_valid  out  1  result fields valid; held until next `go` accepted.
- winner  out  IDX_W  index of first finisher; IDX_W = max(1, clog2(N_RACERS)).
- tie  out  1  more than one racer finished in the winning cycle.
- first_time  out  CNT_W  counter value when the first `done` was seen.
- finished  out  N_RACERS  racers whose `done` rose before race end.
- timeout  out  1  race ended by TIMEOUT, not by all finishing.

Behaviour:
- Reset (async, rst_l=0):
  - state=IDLE.
  - start, busy, result_valid, winner, tie, first_time, finished, timeout all 0.
  - `start` drops immediately, without waiting for a clock edge.
- IDLE:
  - If go=1 at edge E: start<=all ones, busy<=1, result_valid<=0, cnt<=1.
  - At the same edge, finished/winner/tie/first_time/timeout clear to 0; go to RACE.
  - If go=0: stay.
- RACE, on each edge:
  - cnt increments.
  - done_seen |= done_in; `done_seen` is sticky, and a racer dropping `done` early does not clear it.
  - First cycle with any done_in bit high and done_seen==0:
    - winner <= lowest set index.
    - tie <= (more than one bit set).
    - first_time <= cnt.
  - End condition is checked on the same edge, after the done_seen update:
    - all racers seen: start<=0, finished<=mask, timeout<=0, go to RELEASE.
    - else cnt==TIMEOUT: start<=0, finished<=done_seen|done_in, timeout<=1, go to RELEASE.
  - If the timeout fires with no finisher: winner=0, tie=0, first_time=0.
- RELEASE:
  - Wait until done_in==0.
  - Then result_valid<=1, busy<=0, go to IDLE.
  - No release timeout: a stuck observer holds the block in RELEASE.
- Counter width:
  - The counter never exceeds TIMEOUT, so no wrap occurs.
  - first_time is at most TIMEOUT.
- `go` handling:
  - `go` while busy is ignored, not queued.
  - `go` in the same cycle that RELEASE exits is also ignored; the block accepts `go` from the following cycle.
- Simultaneous finish and timeout on the same edge: all-finished wins, timeout=0.
- Illegal state encoding: return to IDLE with outputs as at reset.

Optional Feature:
- Macro: RACE_JUDGE_RANKING_EN.
- When defined:
  - Extra output `place`, width N_RACERS*IDX_W: slot k holds the index of the k-th finisher.
  - Same-cycle finishers are ordered by ascending index.
  - Extra output `place_cnt`, width IDX_W+1: number of valid slots.
  - Both clear on `go` acceptance; unfilled slots read 0.
- When undefined: ports absent, no ranking logic.

Decomposition:
- Package race_pkg:
  - state enum {IDLE, RACE, RELEASE}.
  - IDX_W computation function.
  - Default N_RACERS, TIMEOUT, CNT_W constants.
  - The same constants are reused by the observer bench.
- Sub-module: lowest_set_index.
  - Combinational priority encoder producing index and multi-hot flag.
  - Parameterized on width.
  - Reused by the ranking logic.

Test Plan:
- Reset: hold rst_l=0 mid-RACE with start=4'b1111 -> start=0 before the next edge; all outputs 0, busy=0.
- Single winner: racer 2 raises done at cnt=5, racers 0/1/3 at cnt 8/9/12; all drop done the cycle after start falls -> winner=2, tie=0, first_time=5, finished=4'b1111, timeout=0, result_valid=1.
- Tie: racers 1 and 3 rise at cnt=7, others at cnt=10 -> winner=1, tie=1, first_time=7.
- Timeout (TIMEOUT=20): racer 0 never responds, others finish by cnt=15 -> start falls at the cnt=20 edge, timeout=1, finished=4'b1110.
- Busy protection: pulse go during RACE and in the RELEASE-exit cycle -> no restart; the next go one cycle after IDLE is accepted and clears result_valid.
- Ranking (macro on): finish order 3, 0 and 2 (same cycle), then 1 -> place slots = 3, 0, 2, 1; place_cnt=4.
